// File: rtl/mill_pkg.sv
// Shared definitions for the Modified-Miller reader-to-card decoder.
//
// Contents:
//   ETU_CLKS_DEF  default clocks per bit window (3.39 MHz / 106 kbit/s = 32)
//   EDGE_TOL_DEF  default late-edge tolerance in clocks before a window end
//   state_t       decoder FSM states
//   seq_t         Modified-Miller sequence types seen in one bit window
//   classify()    maps the window's pause flags to a sequence type
package mill_pkg;

    localparam int ETU_CLKS_DEF = 32;
    localparam int EDGE_TOL_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOF  = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEQ_X = 2'd0,   // pause in the second half  -> bit 1
        SEQ_Y = 2'd1,   // no pause                  -> bit 0, or EOF after a 0
        SEQ_Z = 2'd2    // pause at the window start -> bit 0
    } seq_t;

    // A second-half pause always marks an X, even when a Z edge was also seen.
    function automatic seq_t classify(input logic x_seen, input logic z_seen);
        if (x_seen) begin
            return SEQ_X;
        end else if (z_seen) begin
            return SEQ_Z;
        end else begin
            return SEQ_Y;
        end
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a falling-edge detector.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset; loads all flops with 1 so that
//              releasing reset with the line high produces no edge
//   din        asynchronous input level
//   fall_pulse one-clock pulse on a 1-to-0 transition of the synchronized level
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall_pulse
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            sync_p2 <= 1'b1;
        end else begin
            // metastability stages
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            // previous synchronized level, for edge detection
            sync_p2 <= sync_p1;
        end
    end

    assign fall_pulse = sync_p2 & ~sync_p1;

endmodule

// File: rtl/mill_modif_demod.sv
// Modified-Miller decoder (ISO 14443A reader-to-card, 106 kbit/s).
// Converts the active-low pause signal of the envelope detector into an NRZ
// bit stream. The bit grid is anchored on the SOF pause edge and never
// re-aligned within a frame. Each decoded bit appears on the clock after its
// window closes and is held for one full window.
//
// Ports:
//   clk       system clock (3.39 MHz)
//   in_PoR    synchronous active-high reset
//   in_data   demodulated field, asynchronous; 1 = carrier, 0 = pause
//   out_data  decoded bit, held one ETU; 0 while idle
module mill_modif_demod
    import mill_pkg::*;
#(
    parameter int ETU_CLKS = ETU_CLKS_DEF,
    parameter int EDGE_TOL = EDGE_TOL_DEF
) (
    input  logic clk,
    input  logic in_PoR,
    input  logic in_data,
    output logic out_data
);

    localparam int CNT_W = $clog2(ETU_CLKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ETU_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(ETU_CLKS / 2);
    localparam logic [CNT_W-1:0] CNT_LATE = CNT_W'(ETU_CLKS - EDGE_TOL);

    logic             pause_edge;
    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] counter;
    logic             x_flag;
    logic             z_flag;
    logic             z_next;     // late edge already belonging to the next window
    logic             prev_bit;
    logic             window_end;
    seq_t             seq;
    logic             eof;

    sync_edge_det u_sync (
        .clk        (clk),
        .rst        (in_PoR),
        .din        (in_data),
        .fall_pulse (pause_edge)
    );

    always_comb begin
        window_end = (counter == CNT_LAST);
        seq        = classify(x_flag, z_flag);
        // an empty window after a 0 cannot be a Y: it ends the frame
        eof        = (seq == SEQ_Y) && !prev_bit;
        state_d    = state;
        case (state)
            IDLE: begin
                if (pause_edge) begin
                    state_d = SOF;
                end
            end
            SOF: begin
                if (window_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (window_end && eof) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_PoR) begin
            state    <= IDLE;
            counter  <= '0;
            x_flag   <= 1'b0;
            z_flag   <= 1'b0;
            z_next   <= 1'b0;
            prev_bit <= 1'b0;
            out_data <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    // the SOF edge clock is counter 0, so the next clock is 1
                    counter  <= pause_edge ? CNT_W'(1) : '0;
                    x_flag   <= 1'b0;
                    z_flag   <= 1'b0;
                    z_next   <= 1'b0;
                    out_data <= 1'b0;
                end
                SOF: begin
                    counter <= window_end ? '0 : counter + CNT_W'(1);
                    if (window_end) begin
                        prev_bit <= 1'b0;
                        x_flag   <= 1'b0;
                        z_flag   <= 1'b0;
                        z_next   <= 1'b0;
                    end
                end
                DATA: begin
                    counter <= window_end ? '0 : counter + CNT_W'(1);
                    if (!window_end) begin
                        if (pause_edge) begin
                            if (counter < CNT_HALF) begin
                                z_flag <= 1'b1;
                            end else if (counter < CNT_LATE) begin
                                x_flag <= 1'b1;
                            end else begin
                                z_next <= 1'b1;
                            end
                        end
                    end else begin
                        out_data <= (seq == SEQ_X);
                        prev_bit <= (seq == SEQ_X);
                        x_flag   <= 1'b0;
                        // a pause on the last clock is an early Z of the next window
                        z_flag   <= z_next | (pause_edge && (counter >= CNT_LATE));
                        z_next   <= 1'b0;
                    end
                end
                default: begin
                    counter  <= '0;
                    out_data <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mill_modif_demod.sv
module tb_mill_modif_demod;
    import mill_pkg::*;

    localparam int ETU = 32;
    localparam int TOL = 2;
    localparam int N   = 8000;

    logic clk = 1'b0;
    logic in_PoR;
    logic in_data;
    logic out_data;

    always #5 clk = ~clk;

    mill_modif_demod #(.ETU_CLKS(ETU), .EDGE_TOL(TOL)) dut (
        .clk      (clk),
        .in_PoR   (in_PoR),
        .in_data  (in_data),
        .out_data (out_data)
    );

    // stimulus per cycle, pause edges as seen by the decoder, expected output
    logic w [N];
    logic r [N];
    logic edge_at [N + 80];
    logic exp_out [N + 80];

    logic exp_q [$];
    int   idx_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic add_pause(input int f, input int wd);
        for (int i = f; i < f + wd && i < N; i++) w[i] = 1'b0;
    endtask

    // Decode one reset-free segment from window rules: the first edge at or
    // after the idle point anchors the grid; every following 32-clock window
    // is judged by where its pause edges fall.
    task automatic decode(input int s, input int e_end);
        int   t, p0, k, ws;
        logic x, z, zn, prev, found, eof, bitv;
        t = s;
        while (t < e_end) begin
            found = 1'b0;
            p0 = 0;
            for (int e = t; e < e_end; e++) begin
                if (edge_at[e]) begin
                    p0 = e;
                    found = 1'b1;
                    break;
                end
            end
            if (!found) break;
            prev = 1'b0; zn = 1'b0; k = 1; eof = 1'b0;
            while (!eof) begin
                ws = p0 + ETU * k;
                if (ws + ETU - 1 >= e_end) begin
                    t = e_end;
                    break;
                end
                z = zn; x = 1'b0; zn = 1'b0;
                for (int off = 0; off < ETU; off++) begin
                    if (edge_at[ws + off]) begin
                        if (off < ETU / 2) z = 1'b1;
                        else if (off < ETU - TOL) x = 1'b1;
                        else zn = 1'b1;
                    end
                end
                bitv = 1'b0;
                if (x) bitv = 1'b1;
                else if (z || prev) bitv = 1'b0;
                else begin
                    eof = 1'b1;
                    t = ws + ETU;
                end
                if (!eof) begin
                    for (int m = ws + ETU - 1; m < ws + 2 * ETU - 1; m++)
                        if (m < e_end) exp_out[m] = bitv;
                    prev = bitv;
                    k++;
                end
            end
        end
    endtask

    task automatic build_stimulus();
        int t, nw, typ, off, wd;
        for (int i = 0; i < N; i++) begin
            w[i] = 1'b1;
            r[i] = 1'b0;
        end
        for (int i = 0; i < N + 80; i++) begin
            edge_at[i] = 1'b0;
            exp_out[i] = 1'b0;
        end
        // reset held while the line toggles, then released idle
        for (int i = 0; i < 40; i++) r[i] = 1'b1;
        for (int i = 4; i < 34; i++) w[i] = ((i / 4) % 2 == 1) ? 1'b0 : 1'b1;
        // reference frame (SOF, X, Y, Z, Z, EOF) then restart at 6.5 / 8 ETU
        add_pause(100, 13); add_pause(148, 13); add_pause(196, 13);
        add_pause(228, 13); add_pause(308, 13); add_pause(356, 13);
        // Y after 1: SOF, X, none, Z, none, none
        add_pause(500, 13); add_pause(548, 13); add_pause(596, 13);
        // late Z at counter 31 after an X
        add_pause(720, 13); add_pause(768, 13); add_pause(783, 13);
        // X at counter 29, then an edge at counter 30
        add_pause(900, 13); add_pause(961, 8); add_pause(994, 8);
        // reset in window 3, then a fresh frame
        add_pause(1150, 13); add_pause(1198, 13); add_pause(1246, 6);
        r[1256] = 1'b1;
        add_pause(1300, 13); add_pause(1348, 13);
        // random frames
        t = 1500;
        while (t < N - 700) begin
            add_pause(t, 13);
            nw = $urandom_range(1, 8);
            for (int k = 1; k <= nw; k++) begin
                typ = $urandom_range(0, 2);
                wd = $urandom_range(3, 10);
                if (typ == 0) begin
                    off = $urandom_range(16, 28);
                    add_pause(t + ETU * k + off, wd);
                end else if (typ == 1) begin
                    off = ($urandom_range(0, 3) == 0) ? -$urandom_range(1, 2) : $urandom_range(0, 13);
                    add_pause(t + ETU * k + off, wd);
                end
            end
            t = t + ETU * (nw + 4) + $urandom_range(0, 40);
        end
        // a fall driven in cycle i reaches the decoder on clock i+2
        for (int i = 1; i < N; i++)
            if (w[i - 1] && !w[i]) edge_at[i + 2] = 1'b1;
        // each segment after a reset release starts idle
        for (int m = 0; m < N; m++) begin
            if (r[m] && (m == N - 1 || !r[m + 1])) begin
                int e_end;
                e_end = N;
                for (int j = m + 1; j < N; j++) begin
                    if (r[j]) begin
                        e_end = j;
                        break;
                    end
                end
                decode(m + 1, e_end);
            end
        end
    endtask

    // driver
    initial begin
        in_PoR  = 1'b1;
        in_data = 1'b1;
        build_stimulus();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            in_data = w[i];
            in_PoR  = r[i];
            exp_q.push_back(exp_out[i]);
            idx_q.push_back(i);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // monitor
    initial begin
        logic e;
        int   i;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                i = idx_q.pop_front();
                checks++;
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_data cycle %0d: got %b, required %b", i, out_data, e);
                end
                if (i == 90) begin
                    checks++;
                    if (dut.state !== IDLE) begin
                        errors++;
                        $display("FAIL idle_after_release: state %0d, required %0d", dut.state, IDLE);
                    end
                end
            end
        end
    end

    // watchdog
    initial begin
        #((N + 200) * 20);
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
